// File: rtl/pll_md_cfg_ctrl_if.sv
// MD dynamic-configuration port between the PLL sequencer (master) and the PLL (slave).
// mdrdo returns read data the cycle after a READ op.
interface pll_md_cfg_ctrl_if;
  logic [1:0] mdopc;
  logic       mdainc;
  logic [7:0] mdwdi;
  logic [7:0] mdrdo;

  modport master (output mdopc, output mdainc, output mdwdi, input mdrdo);
  modport slave  (input mdopc, input mdainc, input mdwdi, output mdrdo);
endinterface

// File: rtl/pll_md_cfg_ctrl.sv
// PLL configuration sequencer: writes multiplier/divider over MD, verifies by readback, releases reset, qualifies lock.
// Boot-to-lock is RST_CYC+8 cycles plus 2 synchroniser cycles; cfg_req is only honoured in IDLE or ERR.
module pll_md_cfg_ctrl #(
  parameter int         CLK_PERIOD = 20,
  parameter int         MULTI_FAC  = 37,
  parameter int         ODIV_FAC   = 8,
  parameter int         FAC_W      = 8,
  parameter logic [7:0] REG_BASE   = 8'h10,
  parameter int         RST_NS     = 1000,
  parameter int         LOCK_NS    = 200000,
  parameter int         MAX_RETRY  = 3
) (
  input  logic             mdclk,
  input  logic             resetn,
  input  logic             cfg_req,
  input  logic [FAC_W-1:0] cfg_mul,
  input  logic [FAC_W-1:0] cfg_odiv,
  output logic             cfg_ack,
  output logic             busy,
  output logic             err,
  input  logic             pll_lock,
  output logic             pll_rst,
  output logic             lock,
  pll_md_cfg_ctrl_if.master md
);
  localparam int RST_CYC  = (RST_NS + CLK_PERIOD - 1) / CLK_PERIOD;
  localparam int LOCK_CYC = (LOCK_NS + CLK_PERIOD - 1) / CLK_PERIOD;
  localparam int MAX_CYC  = (RST_CYC > LOCK_CYC) ? RST_CYC : LOCK_CYC;
  localparam int CNT_W    = $clog2(MAX_CYC + 1);
  localparam int RTY_W    = $clog2(MAX_RETRY + 1);

  localparam logic [1:0] OP_NOP = 2'b00;
  localparam logic [1:0] OP_WR  = 2'b01;
  localparam logic [1:0] OP_RD  = 2'b10;
  localparam logic [1:0] OP_SA  = 2'b11;

  typedef enum logic [3:0] {
    S_ASSERT_RST, S_SETA, S_WR0, S_WR1, S_SETB, S_RD0, S_RD1, S_CHK,
    S_RELEASE, S_WAIT_LOCK, S_FAIL, S_IDLE, S_ERR
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [RTY_W-1:0] retry, retry_nxt;
  logic [FAC_W-1:0] mul_q, odiv_q;
  logic [7:0]       mul_ext, odiv_ext, rb_mul;
  logic [1:0]       lock_sync;
  logic             lock_s;
  logic             accept;

  assign mul_ext  = 8'(mul_q);
  assign odiv_ext = 8'(odiv_q);
  assign lock_s   = lock_sync[1];
  assign cfg_ack  = accept;
  assign lock     = lock_s & (state == S_IDLE);

  always_ff @(posedge mdclk or negedge resetn) begin
    if (!resetn) lock_sync <= '0;
    else         lock_sync <= {lock_sync[0], pll_lock};
  end

  always_ff @(posedge mdclk or negedge resetn) begin
    if (!resetn) begin
      state  <= S_ASSERT_RST;
      cnt    <= '0;
      retry  <= '0;
      mul_q  <= FAC_W'(MULTI_FAC);
      odiv_q <= FAC_W'(ODIV_FAC);
      rb_mul <= '0;
    end else begin
      state <= state_nxt;
      retry <= retry_nxt;
      // Single timer shared by reset hold and lock timeout; restarts on every state change.
      if (state_nxt != state) cnt <= '0;
      else if (state == S_ASSERT_RST || state == S_WAIT_LOCK) cnt <= cnt + 1'b1;
      if (accept) begin
        mul_q  <= cfg_mul;
        odiv_q <= cfg_odiv;
      end
      if (state == S_RD1) rb_mul <= md.mdrdo;
    end
  end

  always_comb begin
    state_nxt = state;
    retry_nxt = retry;
    accept    = 1'b0;
    md.mdopc  = OP_NOP;
    md.mdainc = 1'b0;
    md.mdwdi  = '0;
    pll_rst   = 1'b1;
    busy      = 1'b1;
    err       = 1'b0;
    case (state)
      S_ASSERT_RST: if (cnt == CNT_W'(RST_CYC - 1)) state_nxt = S_SETA;
      S_SETA: begin
        md.mdopc = OP_SA; md.mdwdi = REG_BASE; state_nxt = S_WR0;
      end
      S_WR0: begin
        md.mdopc = OP_WR; md.mdainc = 1'b1; md.mdwdi = mul_ext; state_nxt = S_WR1;
      end
      S_WR1: begin
        md.mdopc = OP_WR; md.mdwdi = odiv_ext; state_nxt = S_SETB;
      end
      S_SETB: begin
        md.mdopc = OP_SA; md.mdwdi = REG_BASE; state_nxt = S_RD0;
      end
      S_RD0: begin
        md.mdopc = OP_RD; md.mdainc = 1'b1; state_nxt = S_RD1;
      end
      S_RD1: begin
        md.mdopc = OP_RD; state_nxt = S_CHK;
      end
      // Divider readback arrives this cycle and is compared directly off the bus.
      S_CHK: state_nxt = (rb_mul == mul_ext && md.mdrdo == odiv_ext) ? S_RELEASE : S_FAIL;
      S_RELEASE: begin
        pll_rst = 1'b0; state_nxt = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        pll_rst = 1'b0;
        if (lock_s) begin
          state_nxt = S_IDLE;
          retry_nxt = '0;
        end else if (cnt == CNT_W'(LOCK_CYC - 1)) begin
          state_nxt = S_FAIL;
        end
      end
      S_FAIL: begin
        retry_nxt = retry + 1'b1;
        state_nxt = (retry_nxt == RTY_W'(MAX_RETRY)) ? S_ERR : S_ASSERT_RST;
      end
      S_IDLE: begin
        busy = 1'b0; pll_rst = 1'b0; accept = cfg_req;
      end
      S_ERR: begin
        busy = 1'b0; err = 1'b1; accept = cfg_req;
      end
      default: state_nxt = S_ASSERT_RST;
    endcase
    if (accept) begin
      state_nxt = S_ASSERT_RST;
      retry_nxt = '0;
    end
  end
endmodule

// File: tb/tb_pll_md_cfg_ctrl.sv
// Directed + randomised bench for pll_md_cfg_ctrl with a behavioural PLL (MD register file and lock timer).
// Expected timings come from the state-sequence lengths: RST_CYC hold, 7 programming/check cycles, lock via 2-flop sync.
module tb_pll_md_cfg_ctrl;
  localparam int         RST_CYC  = 50;
  localparam int         LOCK_CYC = 10000;
  localparam int         PERIOD   = RST_CYC + LOCK_CYC + 9;
  localparam logic [7:0] REG_BASE = 8'h10;

  logic       mdclk = 1'b0, resetn = 1'b0, cfg_req = 1'b0, pll_lock = 1'b0;
  logic [7:0] cfg_mul = '0, cfg_odiv = '0;
  logic       cfg_ack, busy, err, pll_rst, lock;

  pll_md_cfg_ctrl_if md ();

  pll_md_cfg_ctrl dut (
    .mdclk(mdclk), .resetn(resetn), .cfg_req(cfg_req), .cfg_mul(cfg_mul), .cfg_odiv(cfg_odiv),
    .cfg_ack(cfg_ack), .busy(busy), .err(err), .pll_lock(pll_lock), .pll_rst(pll_rst),
    .lock(lock), .md(md)
  );

  always #10 mdclk = ~mdclk;

  int npass = 0, nfail = 0, ntotal = 0, cyc = 0;

  // PLL model state
  logic [7:0] regs [256];
  logic [7:0] ptr = '0, rd_val = '0;
  bit         rd_pend = 1'b0, rst_prev = 1'b1, attempt_ok = 1'b0, lock_never = 1'b0;
  int         corrupt_n = 0, fail_left = 0, lock_dly = 0, lk_cnt = 0;
  logic [9:0] trace [$];

  always @(negedge mdclk) begin
    rd_pend = 1'b0;
    if (resetn) begin
      if (md.mdopc != 2'b00) trace.push_back({md.mdopc, md.mdwdi});
      case (md.mdopc)
        2'b11: ptr = md.mdwdi;
        2'b01: regs[ptr] = md.mdwdi;
        2'b10: begin
          rd_pend = 1'b1;
          rd_val  = regs[ptr];
          if (ptr == REG_BASE + 8'd1 && corrupt_n > 0) begin
            rd_val = rd_val ^ 8'h5a;
            corrupt_n--;
          end
        end
        default: ;
      endcase
      if (md.mdainc && md.mdopc != 2'b00) ptr = ptr + 8'd1;
    end
    if (pll_rst) begin
      pll_lock = 1'b0;
      lk_cnt   = 0;
    end else begin
      if (rst_prev) begin
        attempt_ok = !lock_never && fail_left == 0;
        if (fail_left > 0) fail_left--;
      end
      if (attempt_ok && lk_cnt >= lock_dly) pll_lock = 1'b1;
      lk_cnt++;
    end
    rst_prev = pll_rst;
  end

  always @(posedge mdclk) begin
    #1;
    md.mdrdo = rd_pend ? rd_val : 8'($urandom);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clk1;
    @(negedge mdclk);
    cyc++;
  endtask

  function automatic logic sig_sel(input int which);
    case (which)
      0:       return pll_rst;
      1:       return lock;
      default: return err;
    endcase
  endfunction

  task automatic wait_sig(input int which, input logic val, input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      if (sig_sel(which) === val) begin
        at = cyc;
        break;
      end
      clk1();
    end
  endtask

  task automatic check_seq(input logic [7:0] mul, input logic [7:0] odiv, input int base);
    logic [9:0] e [6];
    logic [9:0] got;
    e[0] = {2'b11, REG_BASE}; e[1] = {2'b01, mul};  e[2] = {2'b01, odiv};
    e[3] = {2'b11, REG_BASE}; e[4] = {2'b10, 8'h00}; e[5] = {2'b10, 8'h00};
    for (int i = 0; i < 6; i++) begin
      got = (base + i < trace.size()) ? trace[base + i] : 'x;
      chk($sformatf("md_op%0d", base + i), 32'(got), 32'(e[i]));
    end
  endtask

  // Issue a request at the current negedge; s returns the first ASSERT_RST cycle.
  task automatic request(input logic [7:0] mul, input logic [7:0] odiv, output int s);
    cfg_mul = mul; cfg_odiv = odiv; cfg_req = 1'b1;
    #1;
    chk("cfg_ack_accept", 32'(cfg_ack), 32'd1);
    s = cyc + 1;
    clk1();
    cfg_req = 1'b0;
    #1;
    chk("cfg_ack_pulse", 32'(cfg_ack), 32'd0);
    chk("busy_after_acc", 32'(busy), 32'd1);
    chk("lock_dropped", 32'(lock), 32'd0);
    chk("err_cleared", 32'(err), 32'd0);
  endtask

  task automatic run_cfg(input logic [7:0] mul, input logic [7:0] odiv, input int dly);
    int s, at;
    lock_dly = dly;
    trace.delete();
    request(mul, odiv, s);
    wait_sig(0, 1'b0, RST_CYC + 20, at);
    chk("release_cycle", at, s + RST_CYC + 7);
    wait_sig(1, 1'b1, dly + 20, at);
    chk("lock_cycle", at, s + RST_CYC + 7 + dly + 3);
    check_seq(mul, odiv, 0);
    chk("busy_idle", 32'(busy), 32'd0);
    chk("err_idle", 32'(err), 32'd0);
  endtask

  task automatic chk_reset_vals;
    chk("rst_pll_rst", 32'(pll_rst), 32'd1);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_lock", 32'(lock), 32'd0);
    chk("rst_cfg_ack", 32'(cfg_ack), 32'd0);
    chk("rst_mdopc", 32'(md.mdopc), 32'd0);
    chk("rst_mdainc", 32'(md.mdainc), 32'd0);
    chk("rst_mdwdi", 32'(md.mdwdi), 32'd0);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, at, rise;
    logic [7:0] m, o;

    // 1: boot with defaults, lock 10 cycles after release
    lock_dly = 10;
    repeat (3) clk1();
    chk_reset_vals();
    trace.delete();
    resetn = 1'b1;
    s = cyc;
    wait_sig(0, 1'b0, RST_CYC + 20, at);
    chk("boot_release", at, s + RST_CYC + 7);
    wait_sig(1, 1'b1, 40, at);
    chk("boot_lock", at, s + RST_CYC + 7 + 10 + 3);
    check_seq(8'd37, 8'd8, 0);
    chk("boot_err", 32'(err), 32'd0);
    chk("boot_busy", 32'(busy), 32'd0);

    // 2: runtime reconfiguration, then randomised reconfigurations
    chk("lock_before_req", 32'(lock), 32'd1);
    run_cfg(8'h20, 8'h04, 6);
    for (int i = 0; i < 4; i++) run_cfg(8'($urandom), 8'($urandom), int'($urandom_range(0, 20)));

    // 3: first attempt never locks, second does
    m = 8'($urandom); o = 8'($urandom);
    lock_dly = 5; fail_left = 1; trace.delete();
    request(m, o, s);
    wait_sig(0, 1'b0, RST_CYC + 20, at);
    chk("t3_rel1", at, s + RST_CYC + 7);
    wait_sig(0, 1'b1, LOCK_CYC + 20, rise);
    chk("t3_rst_repulse", rise, s + RST_CYC + 8 + LOCK_CYC);
    wait_sig(0, 1'b0, RST_CYC + 20, at);
    chk("t3_rel2", at, s + 2 * RST_CYC + 16 + LOCK_CYC);
    wait_sig(1, 1'b1, 30, at);
    chk("t3_lock", at, s + 2 * RST_CYC + 16 + LOCK_CYC + 5 + 3);
    chk("t3_err", 32'(err), 32'd0);
    check_seq(m, o, 6);

    // 4: never locks -> ERR after MAX_RETRY attempts; request recovers
    lock_never = 1'b1;
    request(8'h11, 8'h03, s);
    wait_sig(2, 1'b1, 3 * PERIOD + 50, at);
    chk("t4_err_cycle", at, s + 3 * PERIOD);
    repeat (5) clk1();
    chk("t4_err_sticky", 32'(err), 32'd1);
    chk("t4_pll_rst", 32'(pll_rst), 32'd1);
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_lock", 32'(lock), 32'd0);
    lock_never = 1'b0;
    run_cfg(8'($urandom), 8'($urandom), 3);

    // 5: corrupted divider readback on first attempt, no PLL release
    m = 8'($urandom); o = 8'($urandom);
    corrupt_n = 1; lock_dly = 2; trace.delete();
    request(m, o, s);
    wait_sig(0, 1'b0, 2 * RST_CYC + 40, at);
    chk("t5_release", at, s + 2 * RST_CYC + 15);
    wait_sig(1, 1'b1, 30, at);
    chk("t5_lock", at, s + 2 * RST_CYC + 15 + 2 + 3);
    check_seq(m, o, 0);
    check_seq(m, o, 6);
    chk("t5_err", 32'(err), 32'd0);

    // 6a: reset during WR0 restores defaults and reboots
    request(8'($urandom), 8'($urandom), s);
    at = -1;
    for (int i = 0; i < RST_CYC + 20; i++) begin
      if (md.mdopc === 2'b01 && md.mdainc === 1'b1) begin
        at = cyc;
        break;
      end
      clk1();
    end
    chk("t6_wr0_seen", at, s + RST_CYC + 1);
    resetn = 1'b0;
    #1;
    chk_reset_vals();
    repeat (3) clk1();
    lock_dly = 7; trace.delete();
    resetn = 1'b1;
    s = cyc;
    wait_sig(0, 1'b0, RST_CYC + 20, at);
    chk("t6_reboot_rel", at, s + RST_CYC + 7);
    wait_sig(1, 1'b1, 30, at);
    chk("t6_reboot_lock", at, s + RST_CYC + 7 + 7 + 3);
    check_seq(8'd37, 8'd8, 0);

    // 6b: request during WAIT_LOCK is ignored; retry reuses old factors
    m = 8'($urandom); o = 8'($urandom);
    fail_left = 1; lock_dly = 4; trace.delete();
    request(m, o, s);
    wait_sig(0, 1'b0, RST_CYC + 20, at);
    chk("t6b_rel1", at, s + RST_CYC + 7);
    clk1();
    cfg_mul = ~m; cfg_odiv = ~o; cfg_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t6b_no_ack", 32'(cfg_ack), 32'd0);
      chk("t6b_busy", 32'(busy), 32'd1);
      clk1();
    end
    cfg_req = 1'b0;
    wait_sig(0, 1'b1, LOCK_CYC + 20, rise);
    chk("t6b_rst_repulse", rise, s + RST_CYC + 8 + LOCK_CYC);
    wait_sig(1, 1'b1, RST_CYC + 40, at);
    chk("t6b_lock", at, s + 2 * RST_CYC + 16 + LOCK_CYC + 4 + 3);
    check_seq(m, o, 6);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end
endmodule
